// File: rtl/universal_shift_register_pkg.sv
// Shared types for the universal shift register.
// Optional feature macro: USR_ROTATE_EN (enables ROL/ROR as multi-step ops).
package usr_pkg;

  // Operation codes accepted with start.
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_SLL  = 3'd2,
    OP_SRL  = 3'd3,
    OP_SRA  = 3'd4,
    OP_ROL  = 3'd5,
    OP_ROR  = 3'd6,
    OP_CLR  = 3'd7
  } usr_op_e;

  // Controller state: idle and accepting, or stepping through a shift.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } usr_state_e;

  // True for ops that take one bit-step per cycle for 'amount' cycles.
  // Without rotate support, ROL/ROR fall through as single-cycle NOPs.
  function automatic logic is_multi_step(usr_op_e op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA: return 1'b1;
`ifdef USR_ROTATE_EN
      OP_ROL, OP_ROR:         return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Request/status bundle between a controller and the universal shift register.
// Optional feature macro: USR_ROTATE_EN (no effect on this bundle).
interface universal_shift_register_if
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  usr_op_e          op;
  logic [CNT_W-1:0] amount;
  logic [WIDTH-1:0] data_in;
  logic             ser_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             ser_out;

  // Controller side: issues requests, observes status.
  modport master (
    output start, op, amount, data_in, ser_in,
    input  ready, done, data_out, ser_out
  );

  // Register side: receives requests, reports status.
  modport slave (
    input  start, op, amount, data_in, ser_in,
    output ready, done, data_out, ser_out
  );

endinterface

// File: rtl/universal_shift_register_step.sv
// Single-position step mux: given the current word, the op and the serial fill
// bit, produces the word after one bit-step and the bit that fell out.
// Optional feature macro: USR_ROTATE_EN (adds the ROL/ROR arms; otherwise
// no rotate wiring exists here).
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d,
  input  usr_op_e          op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] d_next,
  output logic             out_bit
);

  logic             fill_left;   // bit entering the LSB on a left step
  logic             fill_right;  // bit entering the MSB on a right step
  logic [WIDTH-1:0] shl_vec;
  logic [WIDTH-1:0] shr_vec;

  // Choose the bit that enters the vacated end for each op.
  always_comb begin
    fill_left  = ser_in;
    fill_right = ser_in;
    case (op)
      OP_SRA: fill_right = d[WIDTH-1];
`ifdef USR_ROTATE_EN
      OP_ROL: fill_left  = d[WIDTH-1];
      OP_ROR: fill_right = d[0];
`endif
      default: ;
    endcase
  end

  // Per-bit neighbour wiring for the one-position left and right moves.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shl_vec[gi] = fill_left;
      end else begin : g_lsb_n
        assign shl_vec[gi] = d[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_msb
        assign shr_vec[gi] = fill_right;
      end else begin : g_msb_n
        assign shr_vec[gi] = d[gi+1];
      end
    end
  endgenerate

  // Select direction; ops that do not step leave the word untouched.
  always_comb begin
    d_next  = d;
    out_bit = 1'b0;
    case (op)
      OP_SLL: begin
        d_next  = shl_vec;
        out_bit = d[WIDTH-1];
      end
      OP_SRL, OP_SRA: begin
        d_next  = shr_vec;
        out_bit = d[0];
      end
`ifdef USR_ROTATE_EN
      OP_ROL: begin
        d_next  = shl_vec;
        out_bit = d[WIDTH-1];
      end
      OP_ROR: begin
        d_next  = shr_vec;
        out_bit = d[0];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Multi-mode shift register with start/done handshake. Single-cycle ops
// (NOP, LOAD, CLR, zero-amount shifts) finish at the accepting edge; shift
// and rotate ops walk one bit per cycle for 'amount' cycles.
// Optional feature macro: USR_ROTATE_EN (ROL/ROR enabled; otherwise ops 5/6
// behave as NOP).
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                       clk,
  input logic                       rst,
  universal_shift_register_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  usr_state_e       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  usr_op_e          op_reg, op_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             ser_reg, ser_next;
  logic             done_reg, done_next;

  logic [WIDTH-1:0] step_d;
  logic             step_bit;

  // The step mux always works on the latched op so mid-shift changes on
  // the request lines cannot leak in; only ser_in is live per step.
  usr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .d      (data_reg),
    .op     (op_reg),
    .ser_in (bus.ser_in),
    .d_next (step_d),
    .out_bit(step_bit)
  );

  // State and datapath registers; reset aborts any op without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      op_reg    <= OP_NOP;
      data_reg  <= '0;
      ser_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      ser_reg   <= ser_next;
      done_reg  <= done_next;
    end
  end

  // Next-state and datapath update: accept in IDLE, step in SHIFT.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    ser_next   = ser_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (is_multi_step(bus.op) && (bus.amount != '0)) begin
            op_next    = bus.op;
            count_next = bus.amount;
            state_next = SHIFT;
          end else begin
            // Single-cycle ops; zero-amount shifts and disabled rotates
            // fall through here and leave the word and ser_out alone.
            case (bus.op)
              OP_LOAD: data_next = bus.data_in;
              OP_CLR:  data_next = '0;
              default: ;
            endcase
            done_next = 1'b1;
          end
        end
      end

      SHIFT: begin
        data_next  = step_d;
        ser_next   = step_bit;
        count_next = count_reg - CNT_W'(1);
        if (count_reg == CNT_W'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.ready    = (state_reg == IDLE);
  assign bus.done     = done_reg;
  assign bus.data_out = data_reg;
  assign bus.ser_out  = ser_reg;

endmodule
